// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-counter link (transmitter checkers and gray_rx).
package gray_pkg;

    localparam int unsigned CBITS_DEF = 16;
    localparam int unsigned GRAY_MAXW = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } gray_rx_state_t;

    // Zero-extended codes decode correctly: leading zeros stay zero through the XOR chain.
    function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
        logic [GRAY_MAXW-1:0] b;
        b = '0;
        for (int i = 0; i < int'(GRAY_MAXW); i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder: b[i] is the XOR of g[CBITS-1:i].
module gray_to_bin #(
    parameter int unsigned CBITS = 16
) (
    input  logic [CBITS-1:0] gray,
    output logic [CBITS-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < int'(CBITS); i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_rx.sv
// Gray-link receiver: decode, one-up-step check, IDLE/ACQ/LOCKED tracking.
// Optional saturating step-error counter built when GRAY_RX_ERRCNT_EN is defined.
module gray_rx
    import gray_pkg::*;
#(
    parameter int unsigned CBITS      = CBITS_DEF,
    parameter int unsigned LOCK_STEPS = 4,
    parameter int unsigned ERRW       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CBITS-1:0] gray_in,
    input  logic             gray_vld,
    output logic [CBITS-1:0] bin_out,
    output logic             bin_vld,
    output logic             step_err,
    output logic             wrap,
    output logic             locked,
    output logic [ERRW-1:0]  err_cnt
);

    localparam int unsigned GW = $clog2(LOCK_STEPS + 1);

    gray_rx_state_t   state;
    gray_rx_state_t   state_nxt;
    logic [CBITS-1:0] dec;
    logic [CBITS-1:0] prev;
    logic [CBITS-1:0] prev_inc;
    logic [GW-1:0]    good_cnt;
    logic [GW-1:0]    good_cnt_nxt;
    logic             good_c;
    logic             step_err_c;
    logic             wrap_c;

    gray_to_bin #(.CBITS(CBITS)) u_dec (
        .gray (gray_in),
        .bin  (dec)
    );

    // Up-step is modulo 2^CBITS, so all-ones -> 0 counts as good.
    assign prev_inc = prev + CBITS'(1);
    assign good_c   = (dec == prev_inc);
    assign bin_out  = prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (gray_vld) begin
            case (state)
                IDLE:    state_nxt = ACQ;
                ACQ:     if (good_c && (good_cnt == GW'(LOCK_STEPS - 1))) state_nxt = LOCKED;
                LOCKED:  if (!good_c) state_nxt = ACQ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The first sample after IDLE has no reference, so it is never flagged.
    always_comb begin
        step_err_c   = 1'b0;
        wrap_c       = 1'b0;
        good_cnt_nxt = good_cnt;
        if (gray_vld) begin
            case (state)
                IDLE: good_cnt_nxt = '0;
                ACQ: begin
                    if (good_c) begin
                        good_cnt_nxt = good_cnt + GW'(1);
                        wrap_c       = &prev;
                    end else begin
                        step_err_c   = 1'b1;
                        good_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (good_c) begin
                        wrap_c       = &prev;
                    end else begin
                        step_err_c   = 1'b1;
                        good_cnt_nxt = '0;
                    end
                end
                default: good_cnt_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            good_cnt <= '0;
            bin_vld  <= 1'b0;
            step_err <= 1'b0;
            wrap     <= 1'b0;
            locked   <= 1'b0;
        end else begin
            if (gray_vld) begin
                prev <= dec;
            end
            good_cnt <= good_cnt_nxt;
            bin_vld  <= gray_vld;
            step_err <= step_err_c;
            wrap     <= wrap_c;
            locked   <= (state == LOCKED);
        end
    end

`ifdef GRAY_RX_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (step_err_c && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERRW'(1);
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule
